dma_ch_regs: RTL and testbench

DMA_CH_REGS -- requirements
Module: dma_ch_regs

---
 rtl/dma_ch_regs.sv | 183 ++++++++++++++++++
 tb/tb_dma_ch_regs.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_ch_regs.sv
// Per-channel DMA register file: SRC/DST/SIZE/CTRL/STATUS registers, a two-state
// channel FSM with start/abort pulses, status capture and a level interrupt.
module dma_ch_regs #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [5:0]               addr,
  input  logic [DATA_W-1:0]        din,
  input  logic                     write_en,
  input  logic                     read_en,
  output logic [DATA_W-1:0]        dout,
  output logic [NUM_CH*DATA_W-1:0] src_addr,
  output logic [NUM_CH*DATA_W-1:0] dst_addr,
  output logic [NUM_CH*DATA_W-1:0] transfer_size,
  output logic [NUM_CH-1:0]        start,
  output logic [NUM_CH-1:0]        abort,
  output logic [NUM_CH-1:0]        busy,
  input  logic [NUM_CH-1:0]        ch_done,
  input  logic [NUM_CH-1:0]        ch_err,
  output logic                     irq
);
  localparam int unsigned CH_W  = 3;
  localparam int unsigned OFF_W = 3;

  localparam logic [OFF_W-1:0] OFF_SRC    = 3'd0;
  localparam logic [OFF_W-1:0] OFF_DST    = 3'd1;
  localparam logic [OFF_W-1:0] OFF_SIZE   = 3'd2;
  localparam logic [OFF_W-1:0] OFF_CTRL   = 3'd3;
  localparam logic [OFF_W-1:0] OFF_STATUS = 3'd4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } ch_state_e;

  logic [CH_W-1:0]  ch_sel;
  logic [OFF_W-1:0] off_sel;

  ch_state_e [NUM_CH-1:0]              state_q, state_d;
  logic [NUM_CH-1:0][DATA_W-1:0]       src_q, src_d;
  logic [NUM_CH-1:0][DATA_W-1:0]       dst_q, dst_d;
  logic [NUM_CH-1:0][DATA_W-1:0]       size_q, size_d;
  logic [NUM_CH-1:0]                   irq_en_q, irq_en_d;
  logic [NUM_CH-1:0]                   done_q, done_d;
  logic [NUM_CH-1:0]                   err_q, err_d;
  logic [NUM_CH-1:0]                   start_q, start_d;
  logic [NUM_CH-1:0]                   abort_q, abort_d;
  logic [DATA_W-1:0]                   dout_q, dout_d;
  logic                                irq_q, irq_d;
  logic [DATA_W-1:0]                   rdata_c;

  logic act, wr_ch, set_done, set_err;

  assign ch_sel  = addr[5:3];
  assign off_sel = addr[2:0];

  assign src_addr      = src_q;
  assign dst_addr      = dst_q;
  assign transfer_size = size_q;
  assign start         = start_q;
  assign abort         = abort_q;
  assign dout          = dout_q;
  assign irq           = irq_q;

  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      busy[i] = (state_q[i] == ST_ACTIVE);
    end
  end

  // Channel FSMs, register writes and status capture; hardware sets win over W1C.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    size_d   = size_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    err_d    = err_q;
    start_d  = '0;
    abort_d  = '0;
    act      = 1'b0;
    wr_ch    = 1'b0;
    set_done = 1'b0;
    set_err  = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      act      = (state_q[i] == ST_ACTIVE);
      wr_ch    = write_en && (ch_sel == CH_W'(i));
      set_done = act && ch_done[i];
      set_err  = act && ch_err[i];
      if (set_done || set_err) begin
        state_d[i] = ST_IDLE;
      end
      if (wr_ch) begin
        case (off_sel)
          OFF_SRC:  if (!act) src_d[i] = din;
          OFF_DST:  if (!act) dst_d[i] = din;
          OFF_SIZE: if (!act) size_d[i] = din;
          OFF_CTRL: begin
            irq_en_d[i] = din[1];
            if (din[0] && !act) begin
              if (size_q[i] != '0) begin
                start_d[i] = 1'b1;
                state_d[i] = ST_ACTIVE;
              end else begin
                set_err = 1'b1;
              end
            end
            if (din[2] && act) begin
              abort_d[i] = 1'b1;
              state_d[i] = ST_IDLE;
              set_err    = 1'b1;
            end
          end
          OFF_STATUS: begin
            if (din[1]) done_d[i] = 1'b0;
            if (din[2]) err_d[i]  = 1'b0;
          end
          default: ;
        endcase
      end
      if (set_done) done_d[i] = 1'b1;
      if (set_err)  err_d[i]  = 1'b1;
    end
    irq_d = |(irq_en_q & (done_q | err_q));
  end

  // Read mux samples pre-write state; unmapped offsets and channels read zero.
  always_comb begin
    rdata_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_W'(i)) begin
        case (off_sel)
          OFF_SRC:  rdata_c = src_q[i];
          OFF_DST:  rdata_c = dst_q[i];
          OFF_SIZE: rdata_c = size_q[i];
          OFF_CTRL: rdata_c[1] = irq_en_q[i];
          OFF_STATUS: begin
            rdata_c[0] = (state_q[i] == ST_ACTIVE);
            rdata_c[1] = done_q[i];
            rdata_c[2] = err_q[i];
          end
          default: ;
        endcase
      end
    end
    dout_d = read_en ? rdata_c : dout_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
      end
      src_q    <= '0;
      dst_q    <= '0;
      size_q   <= '0;
      irq_en_q <= '0;
      done_q   <= '0;
      err_q    <= '0;
      start_q  <= '0;
      abort_q  <= '0;
      dout_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      size_q   <= size_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
      start_q  <= start_d;
      abort_q  <= abort_d;
      dout_q   <= dout_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_dma_ch_regs.sv
// Scoreboard bench for dma_ch_regs: directed scenarios plus random traffic,
// checked against an array-based register/channel model.
module tb_dma_ch_regs;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [5:0]               addr;
  logic [DATA_W-1:0]        din;
  logic                     write_en;
  logic                     read_en;
  logic [DATA_W-1:0]        dout;
  logic [NUM_CH*DATA_W-1:0] src_addr;
  logic [NUM_CH*DATA_W-1:0] dst_addr;
  logic [NUM_CH*DATA_W-1:0] transfer_size;
  logic [NUM_CH-1:0]        start;
  logic [NUM_CH-1:0]        abort;
  logic [NUM_CH-1:0]        busy;
  logic [NUM_CH-1:0]        ch_done;
  logic [NUM_CH-1:0]        ch_err;
  logic                     irq;

  always #5 clk = ~clk;

  dma_ch_regs #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .write_en(write_en),
    .read_en(read_en), .dout(dout), .src_addr(src_addr), .dst_addr(dst_addr),
    .transfer_size(transfer_size), .start(start), .abort(abort), .busy(busy),
    .ch_done(ch_done), .ch_err(ch_err), .irq(irq)
  );

  typedef struct {
    logic [31:0] dout;
    logic [3:0]  start;
    logic [3:0]  abort;
    logic [3:0]  busy;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model state, indexed by the full 3-bit channel field
  logic [31:0] m_src[8], m_dst[8], m_size[8];
  bit          m_ien[8], m_done[8], m_err[8], m_act[8];
  logic [31:0] m_dout;

  function automatic void chk(string nm, logic [31:0] act_v, logic [31:0] exp_v);
    n_chk++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act_v, exp_v);
    end
  endfunction

  function automatic void m_reset();
    for (int c = 0; c < 8; c++) begin
      m_src[c] = '0; m_dst[c] = '0; m_size[c] = '0;
      m_ien[c] = 0; m_done[c] = 0; m_err[c] = 0; m_act[c] = 0;
    end
    m_dout = '0;
  endfunction

  function automatic logic [31:0] m_read(int ch, int off);
    logic [31:0] v;
    v = '0;
    if (ch < NUM_CH) begin
      case (off)
        0: v = m_src[ch];
        1: v = m_dst[ch];
        2: v = m_size[ch];
        3: v[1] = m_ien[ch];
        4: begin v[0] = m_act[ch]; v[1] = m_done[ch]; v[2] = m_err[ch]; end
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  // One bus cycle: drive inputs, advance the model, queue the expected response.
  task automatic op(input bit we, input bit re, input int ch, input int off,
                    input logic [31:0] d, input logic [3:0] dn, input logic [3:0] er,
                    input bit use_c, input logic [31:0] cval);
    exp_t e;
    bit a, set_d, set_e, go_act, go_idle, irq_pre;
    @(negedge clk);
    write_en = we; read_en = re; addr = {3'(ch), 3'(off)}; din = d;
    ch_done = dn; ch_err = er;
    irq_pre = 0;
    for (int c = 0; c < NUM_CH; c++) irq_pre |= m_ien[c] & (m_done[c] | m_err[c]);
    if (re) m_dout = use_c ? cval : m_read(ch, off);
    e.dout = m_dout; e.irq = irq_pre; e.start = '0; e.abort = '0; e.busy = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      a = m_act[c];
      set_d = a & dn[c];
      set_e = a & er[c];
      go_idle = set_d | set_e;
      go_act = 0;
      if (we && ch == c) begin
        case (off)
          0: if (!a) m_src[c] = d;
          1: if (!a) m_dst[c] = d;
          2: if (!a) m_size[c] = d;
          3: begin
            m_ien[c] = d[1];
            if (d[0] && !a) begin
              if (m_size[c] != 0) begin go_act = 1; e.start[c] = 1'b1; end
              else set_e = 1;
            end
            if (d[2] && a) begin e.abort[c] = 1'b1; go_idle = 1; set_e = 1; end
          end
          4: begin
            if (d[1]) m_done[c] = 0;
            if (d[2]) m_err[c] = 0;
          end
          default: ;
        endcase
      end
      if (set_d) m_done[c] = 1;
      if (set_e) m_err[c] = 1;
      if (go_act) m_act[c] = 1;
      else if (go_idle) m_act[c] = 0;
      e.busy[c] = m_act[c];
    end
    exp_q.push_back(e);
  endtask

  task automatic wr(input int ch, input int off, input logic [31:0] d);
    op(1, 0, ch, off, d, 4'h0, 4'h0, 0, '0);
  endtask

  task automatic rd(input int ch, input int off);
    op(0, 1, ch, off, '0, 4'h0, 4'h0, 0, '0);
  endtask

  task automatic rdc(input int ch, input int off, input logic [31:0] v);
    op(0, 1, ch, off, '0, 4'h0, 4'h0, 1, v);
  endtask

  task automatic pulse(input logic [3:0] dn, input logic [3:0] er);
    op(0, 0, 0, 0, '0, dn, er, 0, '0);
  endtask

  task automatic nop();
    op(0, 0, 0, 0, '0, 4'h0, 4'h0, 0, '0);
  endtask

  task automatic quiesce();
    @(negedge clk);
    write_en = 0; read_en = 0; ch_done = '0; ch_err = '0;
    repeat (2) @(posedge clk);
    #2;
  endtask

  // Monitor: one queued expectation per clock after each issued cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dout", dout, e.dout);
        chk("start", 32'(start), 32'(e.start));
        chk("abort", 32'(abort), 32'(e.abort));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("irq", 32'(irq), 32'(e.irq));
      end
    end
  end

  initial begin
    bit          we, re;
    int          ch, off, waited;
    logic [31:0] d;
    logic [3:0]  dn, er;

    rst = 1; addr = '0; din = '0; write_en = 0; read_en = 0; ch_done = '0; ch_err = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_start", 32'(start), 32'h0);
    @(negedge clk);
    rst = 0;

    // Channel 1 normal transfer with interrupt
    wr(1, 0, 32'h1000); wr(1, 1, 32'h2000); wr(1, 2, 32'd16); wr(1, 3, 32'h3);
    nop(); pulse(4'b0010, 4'b0000); nop();
    rdc(1, 4, 32'h2); nop();
    wr(1, 4, 32'h2); nop(); nop();
    rdc(1, 0, 32'h1000); rdc(1, 1, 32'h2000); rdc(1, 2, 32'd16);

    // Zero-size start on channel 0
    wr(0, 2, 32'h0); wr(0, 3, 32'h1); nop();
    rdc(0, 4, 32'h4);

    // Writes while channel 2 is active, then abort
    wr(2, 2, 32'd8); wr(2, 3, 32'h1); wr(2, 0, 32'hFFFF); wr(2, 3, 32'h1);
    rdc(2, 0, 32'h0); wr(2, 3, 32'h4); nop();
    rdc(2, 4, 32'h4);

    // Simultaneous read and write returns the old value
    op(1, 1, 1, 0, 32'h5555, 4'h0, 4'h0, 1, 32'h1000);
    rdc(1, 0, 32'h5555);

    // Hardware DONE set beats same-cycle W1C on channel 3
    wr(3, 2, 32'd5); wr(3, 3, 32'h1); pulse(4'b1000, 4'b0000);
    wr(3, 3, 32'h1);
    op(1, 0, 3, 4, 32'h2, 4'b1000, 4'b0000, 0, '0);
    rdc(3, 4, 32'h2);

    // Unmapped offsets/channels, and simultaneous events on two channels
    rdc(0, 6, 32'h0); wr(7, 0, 32'h1234); rdc(7, 0, 32'h0); rdc(2, 7, 32'h0);
    wr(0, 4, 32'h6); wr(1, 4, 32'h6); wr(0, 2, 32'd4);
    wr(0, 3, 32'h1); wr(1, 3, 32'h1);
    pulse(4'b0001, 4'b0010);
    rdc(0, 4, 32'h2); rdc(1, 4, 32'h4);

    // Reset in the middle of a channel 1 transfer
    wr(1, 3, 32'h3); nop(); rd(1, 0); nop();
    quiesce();
    chk("pre_busy1", 32'(busy[1]), 32'h1);
    chk("pre_irq", 32'(irq), 32'h1);
    chk("pre_dout", dout, 32'h5555);
    rst = 1;
    #1;
    chk("async_busy", 32'(busy), 32'h0);
    chk("async_irq", 32'(irq), 32'h0);
    chk("async_dout", dout, 32'h0);
    chk("async_abort", 32'(abort), 32'h0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_abort", 32'(abort), 32'h0);
      chk("rst_start", 32'(start), 32'h0);
    end
    @(negedge clk);
    rst = 0;
    m_reset();
    for (int c = 0; c < NUM_CH; c++)
      for (int o = 0; o < 5; o++) rdc(c, o, 32'h0);

    // Randomized traffic against the model
    for (int k = 0; k < 800; k++) begin
      ch  = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 7));
      off = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
      d   = $urandom;
      if (off == 3) d = 32'($urandom_range(0, 7));
      if (off == 4) d = 32'($urandom_range(0, 7));
      if (off == 2 && $urandom_range(0, 3) == 0) d = '0;
      we  = ($urandom_range(0, 2) != 0);
      re  = ($urandom_range(0, 1) != 0);
      dn  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      er  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      op(we, re, ch, off, d, dn, er, 0, '0);
    end

    @(negedge clk);
    write_en = 0; read_en = 0; ch_done = '0; ch_err = '0;
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
